// File: rtl/sw_link_responder.sv
// Single-wire half-duplex responder: receives an 8-bit request, waits out the turnaround gap, replies with request+addend (9 bits).
// Receive path adds 2 clocks of synchroniser latency; no backpressure, the reply is fully paced by BIT_CYCLES/TURN_BITS.
module sw_link_responder #(
  parameter int BIT_CYCLES = 16,
  parameter int TURN_BITS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_addend,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       drive_en,
  inout  wire        pad
);

  localparam int TURN_CYC = TURN_BITS * BIT_CYCLES;
  localparam int TW       = $clog2(TURN_CYC + BIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      bit_cnt;
  logic [7:0]      rx_shift;
  logic [8:0]      reply;
  logic            pad_out;
  logic            sync1;
  logic            pad_s;
  logic            prev;

  assign pad = drive_en ? pad_out : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      pad_s <= 1'b1;
    end else begin
      sync1 <= pad;
      pad_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      reply     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      drive_en  <= 1'b0;
      pad_out   <= 1'b1;
      prev      <= 1'b1;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // Outside IDLE the edge history is pinned high so our own traffic never looks like a new request.
      prev      <= (state == IDLE) ? pad_s : 1'b1;
      if (timer != '0) timer <= timer - 1'b1;

      case (state)
        IDLE: begin
          if (prev && !pad_s) begin
            timer <= TW'(BIT_CYCLES / 2 - 1);
            state <= RX_START;
            busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (pad_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              timer   <= TW'(BIT_CYCLES - 1);
              bit_cnt <= '0;
              state   <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            rx_shift <= {pad_s, rx_shift[7:1]};
            timer    <= TW'(BIT_CYCLES - 1);
            if (bit_cnt == 4'd7) state <= RX_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == '0) begin
            if (!pad_s) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              timer    <= TW'(TURN_CYC - 1);
              state    <= TURN;
            end
          end
        end
        TURN: begin
          // The addend is taken in the rx_valid cycle, so later changes cannot disturb the reply.
          if (rx_valid) reply <= {1'b0, rx_data} + {1'b0, tx_addend};
          if (!pad_s) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (timer == '0) begin
            drive_en <= 1'b1;
            pad_out  <= 1'b0;
            timer    <= TW'(BIT_CYCLES - 1);
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (timer == '0) begin
            pad_out <= reply[0];
            reply   <= reply >> 1;
            bit_cnt <= '0;
            timer   <= TW'(BIT_CYCLES - 1);
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (timer == '0) begin
            timer <= TW'(BIT_CYCLES - 1);
            if (bit_cnt == 4'd8) begin
              pad_out <= 1'b1;
              state   <= TX_STOP;
            end else begin
              pad_out <= reply[0];
              reply   <= reply >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (timer == '0) begin
            drive_en <= 1'b0;
            pad_out  <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_link_responder.sv
// Bench for sw_link_responder: table of request/addend vectors with a reply scoreboard, plus glitch, collision and reset corners.
module tb_sw_link_responder;

  localparam int BC = 16;
  localparam int TB = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_addend = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       drive_en;
  wire        pad;
  logic       tb_oe = 1'b0;
  logic       tb_val = 1'b1;

  assign pad = tb_oe ? tb_val : 1'bz;
  pullup (pad);

  sw_link_responder #(.BIT_CYCLES(BC), .TURN_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_addend(tx_addend), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy),
    .drive_en(drive_en), .pad(pad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] add;
    logic       stop;
    logic       exp_valid;
    logic       exp_err;
    logic [8:0] exp_reply;
  } vec_t;

  logic [8:0] exp_q[$];
  logic [7:0] good_rx = 8'h00;

  // Monitor state, sampled on the falling edge.
  int         cyc = 0;
  int         n_valid, n_err, n_rise, de_len, rv_cyc, rise_cyc;
  logic [7:0] last_rx;
  logic [8:0] obs;
  logic       start_bit, stop_bit, busy_seen;
  logic       de_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int off, idx;
    if (rx_valid) begin n_valid++; last_rx = rx_data; rv_cyc = cyc; end
    if (frame_err) n_err++;
    if (busy) busy_seen = 1'b1;
    if (drive_en) begin
      if (!de_q) begin n_rise++; rise_cyc = cyc; end
      de_len++;
      off = cyc - rise_cyc;
      if (off % BC == BC / 2) begin
        idx = off / BC;
        if (idx == 0) start_bit = pad;
        else if (idx <= 9) obs[idx-1] = pad;
        else stop_bit = pad;
      end
    end
    de_q = drive_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0; n_err = 0; n_rise = 0; de_len = 0; rv_cyc = 0; rise_cyc = 0;
    last_rx = 8'h00; obs = 9'h000; start_bit = 1'b1; stop_bit = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tb_oe = 1'b1;
      tb_val = f[i];
      repeat (BC) @(posedge clk);
      #1;
    end
    tb_oe = 1'b0;
    tb_val = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    clr_mon();
    tx_addend = v.add;
    if (v.exp_valid) exp_q.push_back(v.exp_reply);
    send_frame(v.req, v.stop);
    tx_addend = ~v.add;
    repeat (240) @(posedge clk);
    #1;
    if (v.exp_valid) good_rx = v.req;
    chk("rx_valid_count", n_valid, {31'd0, v.exp_valid});
    chk("frame_err_count", n_err, {31'd0, v.exp_err});
    chk("rx_data", rx_data, good_rx);
    chk("busy_idle", busy, 0);
    if (v.exp_valid) begin
      chk("rx_data_at_valid", last_rx, v.req);
      chk("tx_frames", n_rise, 1);
      chk("turnaround_gap", rise_cyc - rv_cyc, TB * BC);
      chk("drive_len", de_len, 11 * BC);
      chk("tx_start_bit", start_bit, 0);
      chk("tx_stop_bit", stop_bit, 1);
      chk("reply", obs, exp_q.pop_front());
    end else begin
      chk("no_tx_frame", n_rise, 0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h5A, 8'hC3, 1'b1, 1'b1, 1'b0, 9'h11D};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 9'h100};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 9'h000};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 1'b0, 9'h0FF};
    vecs[4] = '{8'h33, 8'h77, 1'b0, 1'b0, 1'b1, 9'h000};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 9'h100};

    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_drive_en", drive_en, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pad", pad, 1);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Short low glitch on an idle line must be rejected as a false start.
    clr_mon();
    tb_oe = 1'b1; tb_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tb_oe = 1'b0; tb_val = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_rx_valid", n_valid, 0);
    chk("glitch_frame_err", n_err, 0);
    chk("glitch_drive", n_rise, 0);
    chk("glitch_busy_low", busy, 0);

    // Initiator keeps hold of the line during the turnaround gap.
    clr_mon();
    tx_addend = 8'h11;
    send_frame(8'h3C, 1'b1);
    tb_oe = 1'b1; tb_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tb_oe = 1'b0; tb_val = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("coll_rx_valid", n_valid, 1);
    chk("coll_frame_err", n_err, 1);
    chk("coll_drive", n_rise, 0);
    chk("coll_busy_low", busy, 0);
    good_rx = 8'h3C;
    chk("coll_rx_data", rx_data, good_rx);

    // Reset asserted in the middle of reply data bit 4.
    clr_mon();
    tx_addend = 8'hC3;
    send_frame(8'h5A, 1'b1);
    begin
      int w;
      w = 0;
      while (!drive_en && w < 400) begin
        @(posedge clk);
        #1;
        w++;
      end
    end
    chk("rst_wait_tx", drive_en, 1);
    repeat (BC * 5 + 4) @(posedge clk);
    #1;
    chk("rst_pre_drive", drive_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_drive_en", drive_en, 0);
    chk("rst_async_pad", pad, 1);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_rx_data", rx_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    good_rx = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
